// File: rtl/vcve2_pkg.sv
// Shared load/store definitions for the cve2 LSU.
package vcve2_pkg;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10
  } ls_type_e;

  // Accesses that cross a word boundary need two bus transactions.
  function automatic logic ls_misaligned(input ls_type_e t, input logic [1:0] off);
    return ((t == LS_WORD) && (off != 2'b00)) || ((t == LS_HALF) && (off == 2'b11));
  endfunction

endpackage

// File: rtl/cve2_lsu_ctrl.sv
// Load/store controller: one outstanding OBI access, splits misaligned
// accesses into two aligned transactions and reassembles load data.
module cve2_lsu_ctrl
  import vcve2_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  ls_type_e    lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        lsu_busy_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_GNT_1, WAIT_RVALID_1, WAIT_GNT_2, WAIT_RVALID_2
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, sign_ext_q, mis_q;
  ls_type_e    type_q;
  logic [23:0] rdata_q;

  logic        idle;
  logic [31:0] cur_addr, cur_wdata, rot_wdata;
  logic        cur_we;
  ls_type_e    cur_type;
  logic [1:0]  off;
  logic [3:0]  be;
  logic        second;

  assign idle   = (state_q == IDLE);
  assign second = (state_q == WAIT_GNT_2);

  // In IDLE the request goes out straight from the live inputs.
  assign cur_addr  = idle ? adder_result_ex_i : addr_q;
  assign cur_wdata = idle ? lsu_wdata_i       : wdata_q;
  assign cur_we    = idle ? lsu_we_i          : we_q;
  assign cur_type  = idle ? lsu_type_i        : type_q;
  assign off       = cur_addr[1:0];

  assign data_req_o = (idle & lsu_req_i) | (state_q == WAIT_GNT_1) | second;

  always_comb begin
    be = 4'b0000;
    if (second) begin
      be = (cur_type == LS_WORD) ? ~(4'b1111 << off) : 4'b0001;
    end else begin
      unique case (cur_type)
        LS_WORD: be = 4'b1111 << off;
        LS_HALF: be = 4'b0011 << off;
        default: be = 4'b0001 << off;
      endcase
    end
  end

  always_comb begin
    unique case (off)
      2'd1:    rot_wdata = {cur_wdata[23:0], cur_wdata[31:24]};
      2'd2:    rot_wdata = {cur_wdata[15:0], cur_wdata[31:16]};
      2'd3:    rot_wdata = {cur_wdata[7:0],  cur_wdata[31:8]};
      default: rot_wdata = cur_wdata;
    endcase
  end

  assign data_addr_o  = !data_req_o ? 32'd0 :
                        second ? {addr_q[31:2] + 30'd1, 2'b00} : {cur_addr[31:2], 2'b00};
  assign data_we_o    = data_req_o & cur_we;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_wdata_o = data_req_o ? rot_wdata : 32'd0;

  // Completion: aligned or errored first part, or any second part.
  logic resp, in_rv2;
  assign in_rv2 = (state_q == WAIT_RVALID_2);
  assign resp   = data_rvalid_i &
                  (((state_q == WAIT_RVALID_1) & (data_err_i | ~mis_q)) | in_rv2);

  assign lsu_resp_valid_o = resp;
  assign load_err_o       = resp & data_err_i & ~we_q;
  assign store_err_o      = resp & data_err_i & we_q;
  assign lsu_busy_o       = ~idle;

  // Low bits of raw hold the requested field; in the second part the upper
  // bytes of the first word are spliced below the new read data.
  logic [31:0] raw, ext;
  always_comb begin
    raw = data_rdata_i >> {addr_q[1:0], 3'b000};
    if (in_rv2) begin
      unique case (addr_q[1:0])
        2'd1:    raw = {data_rdata_i[7:0],  rdata_q};
        2'd2:    raw = {data_rdata_i[15:0], rdata_q[23:8]};
        default: raw = {data_rdata_i[23:0], rdata_q[23:16]};
      endcase
    end
  end

  always_comb begin
    unique case (type_q)
      LS_WORD: ext = raw;
      LS_HALF: ext = {{16{sign_ext_q & raw[15]}}, raw[15:0]};
      default: ext = {{24{sign_ext_q & raw[7]}}, raw[7:0]};
    endcase
  end

  assign lsu_rdata_o = (resp & ~we_q) ? ext : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      mis_q      <= 1'b0;
      type_q     <= LS_WORD;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (lsu_req_i) begin
          addr_q     <= adder_result_ex_i;
          wdata_q    <= lsu_wdata_i;
          we_q       <= lsu_we_i;
          type_q     <= lsu_type_i;
          sign_ext_q <= lsu_sign_ext_i;
          mis_q      <= ls_misaligned(lsu_type_i, adder_result_ex_i[1:0]);
          state_q    <= data_gnt_i ? WAIT_RVALID_1 : WAIT_GNT_1;
        end
        WAIT_GNT_1: if (data_gnt_i) state_q <= WAIT_RVALID_1;
        WAIT_RVALID_1: if (data_rvalid_i) begin
          if (data_err_i || !mis_q) begin
            state_q <= IDLE;
          end else begin
            rdata_q <= data_rdata_i[31:8];
            state_q <= WAIT_GNT_2;
          end
        end
        WAIT_GNT_2:    if (data_gnt_i)    state_q <= WAIT_RVALID_2;
        WAIT_RVALID_2: if (data_rvalid_i) state_q <= IDLE;
        default:       state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_lsu_ctrl.sv
// Directed bench for cve2_lsu_ctrl with hand-computed bus and result values.
module tb_cve2_lsu_ctrl;
  import vcve2_pkg::*;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        lsu_req_i = 0, lsu_we_i = 0, lsu_sign_ext_i = 0;
  ls_type_e    lsu_type_i = LS_WORD;
  logic [31:0] lsu_wdata_i = 0, adder_result_ex_i = 0, data_rdata_i = 0;
  logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
  logic        data_req_o, data_we_o, lsu_resp_valid_o, load_err_o, store_err_o, lsu_busy_o;
  logic [31:0] data_addr_o, data_wdata_o, lsu_rdata_o;
  logic [3:0]  data_be_o;

  int n_cmp = 0, n_bad = 0;

  cve2_lsu_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_wdata_i(lsu_wdata_i),
    .adder_result_ex_i(adder_result_ex_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .lsu_rdata_o(lsu_rdata_o), .lsu_resp_valid_o(lsu_resp_valid_o),
    .load_err_o(load_err_o), .store_err_o(store_err_o), .lsu_busy_o(lsu_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply one cycle's inputs on the falling edge; outputs are read 1 ns later.
  task automatic cyc(input logic req, input logic we, input ls_type_e t, input logic sx,
                     input logic [31:0] wd, input logic [31:0] addr, input logic gnt,
                     input logic rv, input logic err, input logic [31:0] rd);
    @(negedge clk_i);
    lsu_req_i = req; lsu_we_i = we; lsu_type_i = t; lsu_sign_ext_i = sx;
    lsu_wdata_i = wd; adder_result_ex_i = addr; data_gnt_i = gnt;
    data_rvalid_i = rv; data_err_i = err; data_rdata_i = rd;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_rdata_o,
         lsu_resp_valid_o, load_err_o, store_err_o, lsu_busy_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got req=%b be=%b addr=%h busy=%b resp=%b, want all 0",
                        data_req_o, data_be_o, data_addr_o, lsu_busy_o, lsu_resp_valid_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    idle_cyc();
    n_cmp++;
    if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: busy=%b req=%b want 0 0", lsu_busy_o, data_req_o);
    end
  endtask

  task automatic test_aligned_lw();
    cyc(1, 0, LS_WORD, 0, 0, 32'h100, 1, 0, 0, 0);
    n_cmp++;
    if (data_req_o !== 1 || data_addr_o !== 32'h100 || data_be_o !== 4'b1111 || data_we_o !== 0) begin
      n_bad++; $display("FAIL lw_req: req=%b addr=%h be=%b we=%b want 1 00000100 1111 0",
                        data_req_o, data_addr_o, data_be_o, data_we_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || lsu_rdata_o !== 32'hDEADBEEF || load_err_o !== 0 || data_req_o !== 0) begin
      n_bad++; $display("FAIL lw_resp: resp=%b rdata=%h err=%b req=%b want 1 deadbeef 0 0",
                        lsu_resp_valid_o, lsu_rdata_o, load_err_o, data_req_o);
    end
    idle_cyc();
    n_cmp++;
    if (lsu_busy_o !== 0 || lsu_resp_valid_o !== 0) begin
      n_bad++; $display("FAIL lw_done: busy=%b resp=%b want 0 0", lsu_busy_o, lsu_resp_valid_o);
    end
  endtask

  task automatic test_byte_loads();
    cyc(1, 0, LS_BYTE, 1, 0, 32'h103, 1, 0, 0, 0);
    n_cmp++;
    if (data_be_o !== 4'b1000 || data_addr_o !== 32'h100) begin
      n_bad++; $display("FAIL lb_be: be=%b addr=%h want 1000 00000100", data_be_o, data_addr_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h80000000);
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || lsu_rdata_o !== 32'hFFFFFF80) begin
      n_bad++; $display("FAIL lb_signed: resp=%b rdata=%h want 1 ffffff80", lsu_resp_valid_o, lsu_rdata_o);
    end
    cyc(1, 0, LS_BYTE, 0, 0, 32'h103, 1, 0, 0, 0);
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h80000000);
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || lsu_rdata_o !== 32'h00000080) begin
      n_bad++; $display("FAIL lbu: resp=%b rdata=%h want 1 00000080", lsu_resp_valid_o, lsu_rdata_o);
    end
    // signed halfword at offset 2, back-to-back with the previous access
    cyc(1, 0, LS_HALF, 1, 0, 32'h42, 1, 0, 0, 0);
    n_cmp++;
    if (data_be_o !== 4'b1100 || data_addr_o !== 32'h40) begin
      n_bad++; $display("FAIL lh_be: be=%b addr=%h want 1100 00000040", data_be_o, data_addr_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h80011234);
    n_cmp++;
    if (lsu_rdata_o !== 32'hFFFF8001) begin
      n_bad++; $display("FAIL lh_signed: rdata=%h want ffff8001", lsu_rdata_o);
    end
    idle_cyc();
  endtask

  task automatic test_misaligned_sw();
    int resp_cnt = 0;
    cyc(1, 1, LS_WORD, 0, 32'h11223344, 32'h201, 1, 0, 0, 0);
    n_cmp++;
    if (data_addr_o !== 32'h200 || data_be_o !== 4'b1110 || data_wdata_o !== 32'h22334411 || data_we_o !== 1) begin
      n_bad++; $display("FAIL sw_txn1: addr=%h be=%b wdata=%h we=%b want 00000200 1110 22334411 1",
                        data_addr_o, data_be_o, data_wdata_o, data_we_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 0);
    resp_cnt += lsu_resp_valid_o;
    n_cmp++;
    if (data_req_o !== 0 || lsu_busy_o !== 1) begin
      n_bad++; $display("FAIL sw_gap: req=%b busy=%b want 0 1", data_req_o, lsu_busy_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (data_req_o !== 1 || data_addr_o !== 32'h204 || data_be_o !== 4'b0001 || data_wdata_o !== 32'h22334411) begin
      n_bad++; $display("FAIL sw_txn2: req=%b addr=%h be=%b wdata=%h want 1 00000204 0001 22334411",
                        data_req_o, data_addr_o, data_be_o, data_wdata_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    resp_cnt += lsu_resp_valid_o;
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || store_err_o !== 0 || lsu_rdata_o !== 0) begin
      n_bad++; $display("FAIL sw_resp: resp=%b serr=%b rdata=%h want 1 0 00000000",
                        lsu_resp_valid_o, store_err_o, lsu_rdata_o);
    end
    idle_cyc();
    resp_cnt += lsu_resp_valid_o;
    n_cmp++;
    if (resp_cnt !== 1) begin
      n_bad++; $display("FAIL sw_resp_count: got %0d pulses want 1", resp_cnt);
    end
  endtask

  task automatic test_misaligned_lw();
    cyc(1, 0, LS_WORD, 0, 0, 32'h102, 1, 0, 0, 0);
    n_cmp++;
    if (data_be_o !== 4'b1100 || data_addr_o !== 32'h100) begin
      n_bad++; $display("FAIL mlw_txn1: be=%b addr=%h want 1100 00000100", data_be_o, data_addr_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'hAAAA5555);
    // second grant arrives one cycle late
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, LS_WORD, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (data_be_o !== 4'b0011 || data_addr_o !== 32'h104) begin
      n_bad++; $display("FAIL mlw_txn2: be=%b addr=%h want 0011 00000104", data_be_o, data_addr_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h7777BBBB);
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || lsu_rdata_o !== 32'hBBBBAAAA) begin
      n_bad++; $display("FAIL mlw_rdata: resp=%b rdata=%h want 1 bbbbaaaa", lsu_resp_valid_o, lsu_rdata_o);
    end
    idle_cyc();
  endtask

  task automatic test_addr_wrap();
    cyc(1, 0, LS_WORD, 0, 0, 32'hFFFFFFFD, 1, 0, 0, 0);
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h44332211);
    cyc(0, 0, LS_WORD, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (data_addr_o !== 32'h0 || data_be_o !== 4'b0001 || data_req_o !== 1) begin
      n_bad++; $display("FAIL wrap_addr: addr=%h be=%b req=%b want 00000000 0001 1",
                        data_addr_o, data_be_o, data_req_o);
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h88776655);
    n_cmp++;
    if (lsu_rdata_o !== 32'h55443322) begin
      n_bad++; $display("FAIL wrap_rdata: rdata=%h want 55443322", lsu_rdata_o);
    end
    idle_cyc();
  endtask

  task automatic test_gnt_delay_err();
    logic stable = 1'b1;
    cyc(1, 0, LS_HALF, 1, 0, 32'h003, 0, 0, 0, 0);
    n_cmp++;
    if (data_req_o !== 1 || data_addr_o !== 32'h0 || data_be_o !== 4'b1000) begin
      n_bad++; $display("FAIL lh_err_req: req=%b addr=%h be=%b want 1 00000000 1000",
                        data_req_o, data_addr_o, data_be_o);
    end
    for (int i = 0; i < 3; i++) begin
      // live inputs change and stray rvalid arrives; the bus request must not move
      cyc(i == 0, 1, LS_WORD, 0, 32'hFFFFFFFF, 32'h5555AAAB, i == 2, i == 1, 0, 0);
      if (data_req_o !== 1 || data_addr_o !== 32'h0 || data_be_o !== 4'b1000 ||
          data_we_o !== 0 || lsu_resp_valid_o !== 0) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++; $display("FAIL lh_err_stable: request changed while waiting for grant");
    end
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if (lsu_resp_valid_o !== 1 || load_err_o !== 1 || store_err_o !== 0) begin
      n_bad++; $display("FAIL lh_err_resp: resp=%b lerr=%b serr=%b want 1 1 0",
                        lsu_resp_valid_o, load_err_o, store_err_o);
    end
    idle_cyc();
    n_cmp++;
    if (data_req_o !== 0 || lsu_busy_o !== 0) begin
      n_bad++; $display("FAIL lh_err_abort: req=%b busy=%b want 0 0", data_req_o, lsu_busy_o);
    end
  endtask

  task automatic test_reset_mid_access();
    cyc(1, 0, LS_WORD, 0, 0, 32'h101, 1, 0, 0, 0);
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'h12345678);
    cyc(0, 0, LS_WORD, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (lsu_busy_o !== 1 || data_req_o !== 1) begin
      n_bad++; $display("FAIL rst_mid_setup: busy=%b req=%b want 1 1", lsu_busy_o, data_req_o);
    end
    @(negedge clk_i); rst_i = 1'b1; data_gnt_i = 1'b0; #1;
    n_cmp++;
    if (lsu_busy_o !== 0 || data_req_o !== 0 || lsu_resp_valid_o !== 0) begin
      n_bad++; $display("FAIL rst_mid: busy=%b req=%b resp=%b want 0 0 0",
                        lsu_busy_o, data_req_o, lsu_resp_valid_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    cyc(0, 0, LS_WORD, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
    n_cmp++;
    if (lsu_resp_valid_o !== 0 || lsu_busy_o !== 0 || lsu_rdata_o !== 0) begin
      n_bad++; $display("FAIL rst_stray_rvalid: resp=%b busy=%b rdata=%h want 0 0 00000000",
                        lsu_resp_valid_o, lsu_busy_o, lsu_rdata_o);
    end
    idle_cyc();
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_byte_loads();
    test_misaligned_sw();
    test_misaligned_lw();
    test_addr_wrap();
    test_gnt_delay_err();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
